// File: rtl/imem_loader.sv
// Serial program loader: assembles little-endian words from a byte stream and writes them to IMEM.
// Write latency one cycle after the 4th byte; no backpressure, bytes arriving in IDLE/DONE/ERROR are dropped.
module imem_loader #(
    parameter int ADDR_WIDTH     = 14,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_hold,
    output logic [15:0]           word_count,
    output logic [31:0]           checksum
);
    localparam int          TW  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [31:0] CAP = 32'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_DONE, S_ERROR} state_t;

    state_t                state_q, state_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [31:0]           asm_q, asm_d;
    logic [15:0]           word_count_q, word_count_d;
    logic [31:0]           checksum_q, checksum_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic                  busy_q, busy_d, done_q, done_d, error_q, error_d, cpu_hold_q, cpu_hold_d;

    logic [15:0] hdr_n;
    logic        last_word, tmo_hit, in_frame, arm;

    assign hdr_n     = {rx_data, word_count_q[7:0]};
    assign last_word = (32'(word_idx_q) + 32'd1) == 32'(word_count_q);
    // Fires on the idle edge that would bring the count to TIMEOUT_CYCLES-1; a byte on that edge wins.
    assign tmo_hit   = !rx_valid && (tmo_q == TW'(TIMEOUT_CYCLES - 2));
    assign in_frame  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
    assign arm       = start && !in_frame;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_LEN_LO;
            S_LEN_LO: begin
                if (rx_valid)     state_d = S_LEN_HI;
                else if (tmo_hit) state_d = S_ERROR;
            end
            S_LEN_HI: begin
                if (rx_valid) begin
                    if (hdr_n == 16'd0)              state_d = S_DONE;
                    else if ({16'd0, hdr_n} > CAP)   state_d = S_ERROR;
                    else                             state_d = S_DATA;
                end else if (tmo_hit) begin
                    state_d = S_ERROR;
                end
            end
            S_DATA: begin
                if (rx_valid && byte_idx_q == 2'd3 && last_word) state_d = S_DONE;
                else if (tmo_hit)                                 state_d = S_ERROR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        byte_idx_d   = byte_idx_q;
        word_idx_d   = word_idx_q;
        tmo_d        = tmo_q;
        asm_d        = asm_q;
        word_count_d = word_count_q;
        checksum_d   = checksum_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        if (arm) begin
            byte_idx_d   = 2'd0;
            word_idx_d   = '0;
            tmo_d        = '0;
            word_count_d = 16'd0;
            checksum_d   = 32'd0;
        end else if (in_frame) begin
            tmo_d = rx_valid ? '0 : tmo_q + 1'b1;
            if (rx_valid) begin
                if (state_q == S_LEN_LO) word_count_d[7:0]  = rx_data;
                if (state_q == S_LEN_HI) word_count_d[15:8] = rx_data;
                if (state_q == S_DATA) begin
                    asm_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
                        imem_wdata_d = asm_d;
                        checksum_d   = checksum_q ^ asm_d;
                        word_idx_d   = word_idx_q + 1'b1;
                    end
                end
            end
        end

        busy_d     = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_DATA);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERROR);
        cpu_hold_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_idx_q   <= 2'd0;
            word_idx_q   <= '0;
            tmo_q        <= '0;
            asm_q        <= 32'd0;
            word_count_q <= 16'd0;
            checksum_q   <= 32'd0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_hold_q   <= 1'b1;
        end else begin
            byte_idx_q   <= byte_idx_d;
            word_idx_q   <= word_idx_d;
            tmo_q        <= tmo_d;
            asm_q        <= asm_d;
            word_count_q <= word_count_d;
            checksum_q   <= checksum_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            cpu_hold_q   <= cpu_hold_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign cpu_hold   = cpu_hold_q;
    assign word_count = word_count_q;
    assign checksum   = checksum_q;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: scoreboarded IMEM writes plus state/latency/timeout checks.
module tb_imem_loader;
    localparam int AW = 4;
    localparam int TO = 16;

    logic          clk = 1'b0, rst = 1'b0, start = 1'b0, rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          imem_we, busy, done, error, cpu_hold;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata, checksum;
    logic [15:0]   word_count;

    imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold),
        .word_count(word_count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [35:0] exp_q[$];
    logic [31:0] exp_csum = 32'd0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Every write the DUT issues must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(e[35:32]));
                chk("wr_data", imem_wdata, e[31:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [AW-1:0] addr, input logic [31:0] w, input bit expect_wr);
        for (int i = 0; i < 4; i++) begin
            if (i == 3 && expect_wr) begin
                exp_q.push_back({addr, w});
                exp_csum ^= w;
            end
            send_byte(w[8*i +: 8]);
        end
        if (expect_wr) chk("we_latency", 32'(imem_we), 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_start();
        pulse_start();
        exp_csum = 32'd0;
        chk("arm_busy", 32'(busy), 32'd1);
        chk("arm_done", 32'(done), 32'd0);
        chk("arm_error", 32'(error), 32'd0);
        chk("arm_hold", 32'(cpu_hold), 32'd1);
        chk("arm_wcount", 32'(word_count), 32'd0);
        chk("arm_csum", checksum, 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_wcount"}, 32'(word_count), 32'd0);
        chk({tag, "_csum"}, checksum, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_vals("rst0");
        rst = 1'b1;

        // Bytes while IDLE are dropped.
        send_byte(8'h13);
        send_byte(8'h05);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_wcount", 32'(word_count), 32'd0);

        // Two-word image.
        do_start();
        send_byte(8'h02);
        send_byte(8'h00);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_wcount", 32'(word_count), 32'd2);
        send_word(4'd0, 32'h0010_0513, 1'b1);
        chk("t1_mid_done", 32'(done), 32'd0);
        chk("t1_mid_hold", 32'(cpu_hold), 32'd1);
        send_word(4'd1, 32'h0020_0593, 1'b1);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_hold", 32'(cpu_hold), 32'd0);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_csum", checksum, exp_csum);

        // Bytes in DONE are ignored.
        send_word(4'd0, 32'h5555_5555, 1'b0);
        chk("done_sticky", 32'(done), 32'd1);
        chk("done_csum", checksum, exp_csum);

        // Empty image.
        do_start();
        send_byte(8'h00);
        send_byte(8'h00);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_hold", 32'(cpu_hold), 32'd0);
        chk("t2_wcount", 32'(word_count), 32'd0);

        // Oversize header, then capacity boundary.
        do_start();
        send_byte(8'h11);
        send_byte(8'h00);
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_hold", 32'(cpu_hold), 32'd1);
        do_start();
        send_byte(8'h10);
        send_byte(8'h00);
        chk("t3_cap_busy", 32'(busy), 32'd1);
        chk("t3_cap_error", 32'(error), 32'd0);
        chk("t3_cap_wcount", 32'(word_count), 32'd16);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_reset_vals("rst_hdr");

        // Timeout fires exactly 15 idle clocks after the last byte.
        do_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 14) chk("t4_no_early", 32'(error), 32'd0);
            if (k == 15) begin
                chk("t4_error", 32'(error), 32'd1);
                chk("t4_hold", 32'(cpu_hold), 32'd1);
                chk("t4_busy", 32'(busy), 32'd0);
            end
        end

        // Byte 14 clocks after the previous one keeps the frame alive.
        do_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (12) @(negedge clk);
        send_byte(8'hCC);
        chk("t4_alive_err", 32'(error), 32'd0);
        chk("t4_alive_busy", 32'(busy), 32'd1);
        exp_q.push_back({4'd0, 32'hDDCC_BBAA});
        exp_csum ^= 32'hDDCC_BBAA;
        send_byte(8'hDD);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_csum", checksum, exp_csum);

        // Reset mid-word discards the partial word.
        do_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_mid");
        rst = 1'b1;
        do_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(4'd0, 32'hDEAD_BEEF, 1'b1);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_csum", checksum, exp_csum);

        // start during DATA is ignored.
        do_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(4'd0, 32'h1234_5678, 1'b1);
        send_byte(8'h0D);
        send_byte(8'hF0);
        pulse_start();
        chk("t6_busy", 32'(busy), 32'd1);
        chk("t6_wcount", 32'(word_count), 32'd2);
        exp_q.push_back({4'd1, 32'hAD0B_F00D});
        exp_csum ^= 32'hAD0B_F00D;
        send_byte(8'h0B);
        send_byte(8'hAD);
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_csum", checksum, exp_csum);

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
